exe_unit: RTL and testbench

Parametrised execute stage: successor to the 8-bit ALU-plus-flag-register stage. Accepts one operation per cycle through a valid/ready handshake and returns a registered result with four condition flags, each with its own write enable. Adds an iterative multi-cycle multiply. Sits between the decode/register-read stage and write-back; the N/Z/C/V outputs feed branch resolution.

---
 rtl/exe_unit_if.sv | 28 ++
 rtl/exe_unit.sv | 202 ++++++++++++++++++++
 tb/tb_exe_unit.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exe_unit_if.sv
// rtl/exe_unit_if.sv - operation/result bus between decode, execute stage and write-back
interface exe_unit_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [3:0]       op;
    logic [3:0]       flag_we;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             flag_n;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;
    logic             busy;

    modport master (
        output in_valid, opa, opb, op, flag_we,
        input  in_ready, out_valid, out_data, flag_n, flag_z, flag_c, flag_v, busy
    );

    modport slave (
        input  in_valid, opa, opb, op, flag_we,
        output in_ready, out_valid, out_data, flag_n, flag_z, flag_c, flag_v, busy
    );
endinterface

// File: rtl/exe_unit.sv
// rtl/exe_unit.sv - execute stage: single-cycle ALU ops, iterative multiply, NZCV flags with per-flag enables
module exe_unit #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    exe_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_ASR = 4'd8;
    localparam logic [3:0] OP_PSB = 4'd9;
    localparam logic [3:0] OP_INC = 4'd10;
    localparam logic [3:0] OP_DEC = 4'd11;
    localparam logic [3:0] OP_MUL = 4'd12;
    localparam logic [3:0] OP_CMP = 4'd13;

    typedef enum logic {
        S_IDLE,
        S_MUL_RUN
    } state_t;

    state_t state_q, state_d;

    logic                 accept;
    logic                 mul_start;
    logic                 mul_last;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0]   mul_sum;
    logic [WIDTH-1:0]     mplier_q;
    logic [CW-1:0]        cnt_q;
    logic [3:0]           we_q;

    logic                 valid_q;
    logic [WIDTH-1:0]     data_q;
    logic [3:0]           flags_q;

    logic                 subtract;
    logic [WIDTH-1:0]     arith_b;
    logic [WIDTH-1:0]     add_b;
    logic [WIDTH:0]       sum;
    logic                 arith_v;

    logic [WIDTH-1:0]     alu_res;
    logic [WIDTH-1:0]     flag_src;
    logic                 alu_c;
    logic                 alu_v;
    logic                 alu_has_flags;

    logic                 wb_valid;
    logic [WIDTH-1:0]     wb_data;
    logic [3:0]           wb_flags;
    logic [3:0]           wb_we;
    logic                 mul_hi;

    assign accept    = bus.in_valid && (state_q == S_IDLE);
    assign mul_start = accept && (bus.op == OP_MUL);
    assign mul_last  = (state_q == S_MUL_RUN) && (cnt_q == LAST_ITER);

    // One shared adder: subtraction is A + ~B + 1, so carry-out inverted is the borrow
    always_comb begin
        subtract = (bus.op == OP_SUB) || (bus.op == OP_CMP) || (bus.op == OP_DEC);
        arith_b  = ((bus.op == OP_INC) || (bus.op == OP_DEC)) ? {{(WIDTH-1){1'b0}}, 1'b1} : bus.opb;
        add_b    = subtract ? ~arith_b : arith_b;
        sum      = {1'b0, bus.opa} + {1'b0, add_b} + {{WIDTH{1'b0}}, subtract};
        arith_v  = (bus.opa[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != bus.opa[WIDTH-1]);
    end

    always_comb begin
        alu_res       = '0;
        alu_c         = 1'b0;
        alu_v         = 1'b0;
        alu_has_flags = 1'b1;
        case (bus.op)
            OP_ADD, OP_INC: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = arith_v;
            end
            OP_SUB, OP_DEC: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = ~sum[WIDTH];
                alu_v   = arith_v;
            end
            OP_CMP: begin
                alu_res = bus.opa;
                alu_c   = ~sum[WIDTH];
                alu_v   = arith_v;
            end
            OP_AND: alu_res = bus.opa & bus.opb;
            OP_OR:  alu_res = bus.opa | bus.opb;
            OP_XOR: alu_res = bus.opa ^ bus.opb;
            OP_NOT: alu_res = ~bus.opa;
            OP_PSB: alu_res = bus.opb;
            OP_SHL: begin
                alu_res = {bus.opa[WIDTH-2:0], 1'b0};
                alu_c   = bus.opa[WIDTH-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, bus.opa[WIDTH-1:1]};
                alu_c   = bus.opa[0];
            end
            OP_ASR: begin
                alu_res = {bus.opa[WIDTH-1], bus.opa[WIDTH-1:1]};
                alu_c   = bus.opa[0];
            end
            default: alu_has_flags = 1'b0;
        endcase
        flag_src = (bus.op == OP_CMP) ? sum[WIDTH-1:0] : alu_res;
    end

    assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
    assign mul_hi  = |mul_sum[2*WIDTH-1:WIDTH];

    // Result/flag write-back source: finishing multiply or a single-cycle op accepted now
    always_comb begin
        wb_valid = 1'b0;
        wb_data  = '0;
        wb_flags = 4'b0000;
        wb_we    = 4'b0000;
        if (mul_last) begin
            wb_valid = 1'b1;
            wb_data  = mul_sum[WIDTH-1:0];
            wb_flags = {mul_sum[WIDTH-1], (mul_sum[WIDTH-1:0] == '0), mul_hi, mul_hi};
            wb_we    = we_q;
        end else if (accept && !mul_start) begin
            wb_valid = 1'b1;
            wb_data  = alu_res;
            wb_flags = {flag_src[WIDTH-1], (flag_src == '0), alu_c, alu_v};
            wb_we    = alu_has_flags ? bus.flag_we : 4'b0000;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (mul_start) state_d = S_MUL_RUN;
            S_MUL_RUN: if (mul_last)  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            flags_q  <= 4'b0000;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            we_q     <= 4'b0000;
        end else begin
            valid_q <= wb_valid;
            if (wb_valid) begin
                data_q <= wb_data;
            end
            for (int i = 0; i < 4; i++) begin
                if (wb_we[i]) flags_q[i] <= wb_flags[i];
            end
            if (mul_start) begin
                acc_q    <= '0;
                mcand_q  <= {{WIDTH{1'b0}}, bus.opa};
                mplier_q <= bus.opb;
                cnt_q    <= '0;
                we_q     <= bus.flag_we;
            end else if (state_q == S_MUL_RUN) begin
                acc_q    <= mul_sum;
                mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
                mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
                cnt_q    <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.busy      = (state_q == S_MUL_RUN);
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.flag_n    = flags_q[3];
    assign bus.flag_z    = flags_q[2];
    assign bus.flag_c    = flags_q[1];
    assign bus.flag_v    = flags_q[0];
endmodule

// File: tb/tb_exe_unit.sv
// tb/tb_exe_unit.sv - scoreboard bench for exe_unit (WIDTH=8)
module tb_exe_unit;
    localparam int W = 8;

    typedef struct packed {
        logic [7:0] d;
        logic [3:0] f;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exe_unit_if #(.WIDTH(W)) bus();
    exe_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    exp_t sb_q[$];
    exp_t got;
    logic [3:0] m_f;
    int checks = 0;
    int errors = 0;
    int pulses = 0;

    function automatic logic [3:0] dut_flags();
        return {bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v};
    endfunction

    // Reference: integer arithmetic with signed range tests for overflow
    task automatic model_push(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic [3:0] we);
        int ua, ub, sa, sb, full, sres;
        logic [7:0] r;
        logic [7:0] d;
        logic c, v, fl;
        logic [3:0] nf;
        exp_t e;
        ua = a; ub = b;
        sa = int'($signed(a)); sb = int'($signed(b));
        c = 1'b0; v = 1'b0; fl = 1'b1; r = 8'h00; full = 0; sres = 0;
        case (op)
            4'd0:  begin full = ua + ub; r = full[7:0]; c = full > 255; sres = sa + sb; v = sres > 127 || sres < -128; end
            4'd1, 4'd13: begin full = ua - ub; r = full[7:0]; c = ua < ub; sres = sa - sb; v = sres > 127 || sres < -128; end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = ~a;
            4'd6:  begin full = ua * 2; r = full[7:0]; c = a[7]; end
            4'd7:  begin full = ua / 2; r = full[7:0]; c = a[0]; end
            4'd8:  begin full = sa / 2 - ((sa < 0 && a[0]) ? 1 : 0); r = full[7:0]; c = a[0]; end
            4'd9:  r = b;
            4'd10: begin full = ua + 1; r = full[7:0]; c = full > 255; sres = sa + 1; v = sres > 127; end
            4'd11: begin full = ua - 1; r = full[7:0]; c = ua < 1; sres = sa - 1; v = sres < -128; end
            4'd12: begin full = ua * ub; r = full[7:0]; c = full > 255; v = c; end
            default: fl = 1'b0;
        endcase
        nf = {r[7], r == 8'h00, c, v};
        d = (op == 4'd13) ? a : r;
        if (fl) begin
            for (int i = 0; i < 4; i++) if (we[i]) m_f[i] = nf[i];
        end
        e.d = d;
        e.f = m_f;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst && bus.out_valid) begin
            pulses++;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_out data=%h flags=%b", bus.out_data, dut_flags());
            end else begin
                got = sb_q.pop_front();
                if ({bus.out_data, dut_flags()} !== {got.d, got.f}) begin
                    errors++;
                    $display("FAIL sb_result data=%h flags(nzcv)=%b required data=%h flags=%b",
                             bus.out_data, dut_flags(), got.d, got.f);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge with in_valid still high
    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic [3:0] we);
        int n;
        bus.in_valid = 1'b1;
        bus.op = op; bus.opa = a; bus.opb = b; bus.flag_we = we;
        n = 0;
        while (!bus.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus.in_ready) begin
            errors++;
            $display("FAIL accept_timeout in_ready=%b required 1", bus.in_ready);
        end else begin
            @(posedge clk);
            model_push(op, a, b, we);
            @(negedge clk);
        end
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s drain pending=%0d required 0", name, sb_q.size());
        end
    endtask

    task automatic check_out(input string name, input logic [7:0] d, input logic [3:0] f);
        checks++;
        if ({bus.out_data, dut_flags()} !== {d, f}) begin
            errors++;
            $display("FAIL %s data=%h flags=%b required data=%h flags=%b", name, bus.out_data, dut_flags(), d, f);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.in_valid = 1'b0; bus.op = 4'd0; bus.opa = 8'h00; bus.opb = 8'h00; bus.flag_we = 4'h0;
        m_f = 4'b0000;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.busy, bus.out_data, dut_flags()} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs valid=%b busy=%b data=%h flags=%b required all 0",
                     bus.out_valid, bus.busy, bus.out_data, dut_flags());
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready in_ready=%b required 1", bus.in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_add();
        send(4'd0, 8'h7F, 8'h01, 4'hF);
        idle();
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL add_latency out_valid=%b required 1", bus.out_valid);
        end
        drain("add");
        check_out("add_const", 8'h80, 4'b1001);
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = pulses;
        send(4'd1, 8'h05, 8'h05, 4'hF);
        send(4'd13, 8'h03, 8'h04, 4'hF);
        idle();
        drain("sub_cmp");
        check_out("cmp_const", 8'h03, 4'b1010);
        checks++;
        if (pulses - p0 != 2) begin
            errors++;
            $display("FAIL b2b_pulses got=%0d required 2", pulses - p0);
        end
    endtask

    task automatic test_mul();
        int low, early;
        send(4'd12, 8'h12, 8'h0B, 4'hF);
        bus.op = 4'd0; bus.opa = 8'h01; bus.opb = 8'h02;
        low = 1; early = 0;
        while (!bus.in_ready && low < 40) begin
            if (bus.out_valid) early++;
            @(negedge clk);
            low++;
        end
        checks++;
        if (low - 1 != 8) begin
            errors++;
            $display("FAIL mul_busy_cycles got=%0d required 8", low - 1);
        end
        checks++;
        if (early != 0 || bus.out_valid !== 1'b1 || bus.out_data !== 8'hC6) begin
            errors++;
            $display("FAIL mul_out early=%0d valid=%b data=%h required early=0 valid=1 data=c6",
                     early, bus.out_valid, bus.out_data);
        end
        send(4'd0, 8'h01, 8'h02, 4'hF);
        idle();
        drain("mul");
    endtask

    task automatic test_mul_flags();
        send(4'd12, 8'h10, 8'h10, 4'hF);
        idle();
        drain("mul_ovf");
        check_out("mul_ovf_const", 8'h00, 4'b0111);
        send(4'd4, 8'hFF, 8'h0F, 4'h8);
        idle();
        drain("xor_we");
        check_out("xor_we_const", 8'hF0, 4'b1111);
    endtask

    task automatic test_shift();
        send(4'd6, 8'h81, 8'h00, 4'hF);
        send(4'd8, 8'h81, 8'h00, 4'hF);
        idle();
        drain("shift");
        check_out("asr_const", 8'hC0, 4'b1010);
    endtask

    task automatic test_random_mix();
        send(4'd14, 8'h33, 8'h44, 4'hF);
        send(4'd10, 8'h7F, 8'h00, 4'hF);
        send(4'd11, 8'h80, 8'h00, 4'hF);
        send(4'd10, 8'hFF, 8'h00, 4'hF);
        for (int i = 0; i < 40; i++) begin
            send(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 4'($urandom));
        end
        idle();
        drain("random");
    endtask

    task automatic test_reset_mid_mul();
        int p0;
        send(4'd12, 8'h12, 8'h0B, 4'hF);
        idle();
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.busy, bus.out_data, dut_flags()} !== 14'd0) begin
            errors++;
            $display("FAIL midmul_reset valid=%b busy=%b data=%h flags=%b required all 0",
                     bus.out_valid, bus.busy, bus.out_data, dut_flags());
        end
        sb_q.delete();
        m_f = 4'b0000;
        p0 = pulses;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midmul_in_ready in_ready=%b required 1", bus.in_ready);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (pulses != p0) begin
            errors++;
            $display("FAIL midmul_no_pulse got=%0d required 0", pulses - p0);
        end
        send(4'd0, 8'h01, 8'h01, 4'hF);
        idle();
        drain("post_reset");
        check_out("post_reset_const", 8'h02, 4'b0000);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_mul();
        test_mul_flags();
        test_shift();
        test_random_mix();
        test_reset_mid_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
